// File: rtl/usb_uart_stream_adapter_pkg.sv
// Shared definitions for the USB CDC byte-port stream adapter:
// byte width, FSM state encodings and the holdoff counter helper.
package usb_uart_stream_adapter_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_WRITE = 2'd1,
        TX_HOLD  = 2'd2
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE = 2'd0,
        RX_READ = 2'd1,
        RX_HOLD = 2'd2
    } rx_state_t;

    // HOLD exits when the counter reaches zero, so it is loaded with holdoff-1.
    function automatic logic [2:0] holdoff_load(input int n);
        return 3'(n - 1);
    endfunction

endpackage

// File: rtl/usb_uart_stream_adapter_if.sv
// User stream and CDC byte-port signals of the adapter.
// The adapter uses the slave view; user logic / core side uses master.
interface usb_uart_stream_adapter_if #(
    parameter int TX_DEPTH = 16,
    parameter int RX_DEPTH = 16
);
    import usb_uart_stream_adapter_pkg::*;

    logic [BYTE_W-1:0]              tx_data;
    logic                           tx_valid;
    logic                           tx_ready;
    logic [BYTE_W-1:0]              rx_data;
    logic                           rx_valid;
    logic                           rx_ready;
    logic [$clog2(TX_DEPTH+1)-1:0]  tx_level;
    logic [$clog2(RX_DEPTH+1)-1:0]  rx_level;
    logic                           uart_we;
    logic [BYTE_W-1:0]              uart_di;
    logic                           uart_wait;
    logic                           uart_re;
    logic [BYTE_W-1:0]              uart_do;
    logic                           uart_ready;

    modport slave (
        input  tx_data, tx_valid, rx_ready, uart_wait, uart_do, uart_ready,
        output tx_ready, rx_data, rx_valid, tx_level, rx_level, uart_we, uart_di, uart_re
    );

    modport master (
        output tx_data, tx_valid, rx_ready, uart_wait, uart_do, uart_ready,
        input  tx_ready, rx_data, rx_valid, tx_level, rx_level, uart_we, uart_di, uart_re
    );

endinterface

// File: rtl/usb_uart_stream_adapter_fifo.sv
// Synchronous first-word-fall-through byte FIFO; head reads as zero when empty
// so no stale byte is ever visible after reset or drain.
module usb_uart_stream_adapter_fifo
    import usb_uart_stream_adapter_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic [BYTE_W-1:0] i_din,
    input  logic              i_pop,
    output logic [BYTE_W-1:0] o_dout,
    output logic              o_full,
    output logic              o_empty,
    output logic [AW:0]       o_level
);

    logic [BYTE_W-1:0] r_mem [DEPTH];
    logic [AW:0]       r_wr_ptr;
    logic [AW:0]       r_rd_ptr;
    logic              w_push_ok;
    logic              w_pop_ok;

    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_push_ok = i_push && !o_full;
    assign w_pop_ok  = i_pop && !o_empty;
    assign o_level   = r_wr_ptr - r_rd_ptr;
    assign o_dout    = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= i_din;
    end

endmodule

// File: rtl/usb_uart_stream_adapter.sv
// Bridges user valid/ready byte streams to the CDC core's uart_we/uart_re
// pulse handshakes, with a FIFO and a strobe/holdoff FSM per direction.
module usb_uart_stream_adapter
    import usb_uart_stream_adapter_pkg::*;
#(
    parameter int TX_DEPTH   = 16,
    parameter int RX_DEPTH   = 16,
    parameter int WE_HOLDOFF = 1,
    parameter int RE_HOLDOFF = 1
) (
    input  logic                      clk_48mhz,
    input  logic                      reset,
    usb_uart_stream_adapter_if.slave  bus
);

    logic              w_tx_full, w_tx_empty, w_tx_pop;
    logic [BYTE_W-1:0] w_tx_head;
    logic              w_rx_full, w_rx_empty, w_rx_push;
    logic              w_uart_we, w_uart_re;
    tx_state_t         r_tx_state, w_tx_next;
    rx_state_t         r_rx_state, w_rx_next;
    logic [2:0]        r_we_cnt, r_re_cnt;
    logic [BYTE_W-1:0] r_uart_di;

    usb_uart_stream_adapter_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk(clk_48mhz), .rst(reset),
        .i_push(bus.tx_valid), .i_din(bus.tx_data), .i_pop(w_tx_pop),
        .o_dout(w_tx_head), .o_full(w_tx_full), .o_empty(w_tx_empty),
        .o_level(bus.tx_level)
    );

    usb_uart_stream_adapter_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk(clk_48mhz), .rst(reset),
        .i_push(w_rx_push), .i_din(bus.uart_do), .i_pop(bus.rx_ready),
        .o_dout(bus.rx_data), .o_full(w_rx_full), .o_empty(w_rx_empty),
        .o_level(bus.rx_level)
    );

    assign bus.tx_ready = !w_tx_full;
    assign bus.rx_valid = !w_rx_empty;
    assign bus.uart_we  = w_uart_we;
    assign bus.uart_re  = w_uart_re;
    assign bus.uart_di  = r_uart_di;

    // TX path: state register, next state, outputs
    always_ff @(posedge clk_48mhz or posedge reset) begin
        if (reset) begin
            r_tx_state <= TX_IDLE;
            r_we_cnt   <= '0;
            r_uart_di  <= '0;
        end else begin
            r_tx_state <= w_tx_next;
            if (w_tx_pop) r_uart_di <= w_tx_head;
            if (r_tx_state == TX_WRITE)
                r_we_cnt <= holdoff_load(WE_HOLDOFF);
            else if (r_tx_state == TX_HOLD && r_we_cnt != 3'd0)
                r_we_cnt <= r_we_cnt - 3'd1;
        end
    end

    always_comb begin
        w_tx_next = r_tx_state;
        case (r_tx_state)
            TX_IDLE:  if (!w_tx_empty && !bus.uart_wait) w_tx_next = TX_WRITE;
            TX_WRITE: w_tx_next = TX_HOLD;
            TX_HOLD:  if (r_we_cnt == 3'd0) w_tx_next = TX_IDLE;
            default:  w_tx_next = TX_IDLE;
        endcase
    end

    always_comb begin
        w_tx_pop  = 1'b0;
        w_uart_we = 1'b0;
        case (r_tx_state)
            TX_IDLE:  w_tx_pop  = !w_tx_empty && !bus.uart_wait;
            TX_WRITE: w_uart_we = 1'b1;
            default:  ;
        endcase
    end

    // RX path: byte is captured in IDLE, strobe acknowledges it the next cycle
    always_ff @(posedge clk_48mhz or posedge reset) begin
        if (reset) begin
            r_rx_state <= RX_IDLE;
            r_re_cnt   <= '0;
        end else begin
            r_rx_state <= w_rx_next;
            if (r_rx_state == RX_READ)
                r_re_cnt <= holdoff_load(RE_HOLDOFF);
            else if (r_rx_state == RX_HOLD && r_re_cnt != 3'd0)
                r_re_cnt <= r_re_cnt - 3'd1;
        end
    end

    always_comb begin
        w_rx_next = r_rx_state;
        case (r_rx_state)
            RX_IDLE: if (bus.uart_ready && !w_rx_full) w_rx_next = RX_READ;
            RX_READ: w_rx_next = RX_HOLD;
            RX_HOLD: if (r_re_cnt == 3'd0) w_rx_next = RX_IDLE;
            default: w_rx_next = RX_IDLE;
        endcase
    end

    always_comb begin
        w_rx_push = 1'b0;
        w_uart_re = 1'b0;
        case (r_rx_state)
            RX_IDLE: w_rx_push = bus.uart_ready && !w_rx_full;
            RX_READ: w_uart_re = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_usb_uart_stream_adapter.sv
// Scoreboard bench for usb_uart_stream_adapter: stimulus queues expected bytes,
// a negedge monitor pops and compares on uart_we and on rx consumption.
module tb_usb_uart_stream_adapter;

    logic clk;
    logic reset;
    usb_uart_stream_adapter_if #(.TX_DEPTH(16), .RX_DEPTH(16)) bus ();

    usb_uart_stream_adapter #(
        .TX_DEPTH(16), .RX_DEPTH(16), .WE_HOLDOFF(1), .RE_HOLDOFF(1)
    ) dut (
        .clk_48mhz(clk),
        .reset(reset),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] tx_exp[$];
    logic [7:0] rx_exp[$];
    logic [7:0] core_q[$];
    int we_times[$];
    int n_vec = 0;
    int n_miss = 0;
    int we_cnt = 0;
    int re_cnt = 0;
    int cyc = 0;
    bit model_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Scoreboard monitor
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (bus.uart_we) begin
                    we_cnt++;
                    we_times.push_back(cyc);
                    if (tx_exp.size() == 0) chk("tx_unexpected_we", {24'd0, bus.uart_di}, 32'hFFFF_FFFF);
                    else chk("tx_byte", {24'd0, bus.uart_di}, {24'd0, tx_exp.pop_front()});
                end
                if (bus.rx_valid && bus.rx_ready) begin
                    if (rx_exp.size() == 0) chk("rx_unexpected_byte", {24'd0, bus.rx_data}, 32'hFFFF_FFFF);
                    else chk("rx_byte", {24'd0, bus.rx_data}, {24'd0, rx_exp.pop_front()});
                end
            end
        end
    end

    // CDC core model: presents core_q head, consumes it on each uart_re strobe
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (model_en) begin
                if (!reset && bus.uart_re) begin
                    re_cnt++;
                    if (core_q.size() != 0) void'(core_q.pop_front());
                end
                bus.uart_ready = (core_q.size() != 0);
                bus.uart_do    = (core_q.size() != 0) ? core_q[0] : 8'h00;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tx_push(input logic [7:0] b, input int budget, output bit ok);
        ok = 1'b0;
        bus.tx_valid = 1'b1;
        bus.tx_data  = b;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (bus.tx_ready) ok = 1'b1;
            step();
        end
        bus.tx_valid = 1'b0;
        if (ok) tx_exp.push_back(b);
    endtask

    task automatic offer_rx(input logic [7:0] b);
        core_q.push_back(b);
        rx_exp.push_back(b);
    endtask

    task automatic wait_drain(input string nm, input int budget);
        int n;
        n = 0;
        while ((tx_exp.size() != 0 || rx_exp.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(nm, (tx_exp.size() != 0 || rx_exp.size() != 0) ? 32'd1 : 32'd0, 32'd0);
    endtask

    initial begin
        bit ok;
        int acc, base_we, base_re, n;
        reset = 1'b1;
        bus.tx_valid = 1'b0; bus.tx_data = 8'h00; bus.rx_ready = 1'b0;
        bus.uart_wait = 1'b0; bus.uart_ready = 1'b0; bus.uart_do = 8'h00;

        // T1: reset with random inputs
        for (int i = 0; i < 5; i++) begin
            step();
            bus.tx_valid   = 1'($urandom);
            bus.tx_data    = 8'($urandom);
            bus.rx_ready   = 1'($urandom);
            bus.uart_wait  = 1'($urandom);
            bus.uart_ready = 1'($urandom);
            bus.uart_do    = 8'($urandom);
        end
        @(negedge clk);
        chk("rst_uart_we", {31'd0, bus.uart_we}, 32'd0);
        chk("rst_uart_re", {31'd0, bus.uart_re}, 32'd0);
        chk("rst_tx_ready", {31'd0, bus.tx_ready}, 32'd1);
        chk("rst_rx_valid", {31'd0, bus.rx_valid}, 32'd0);
        chk("rst_tx_level", {27'd0, bus.tx_level}, 32'd0);
        chk("rst_rx_level", {27'd0, bus.rx_level}, 32'd0);
        chk("rst_uart_di", {24'd0, bus.uart_di}, 32'd0);
        chk("rst_rx_data", {24'd0, bus.rx_data}, 32'd0);
        step();
        reset = 1'b0;
        bus.tx_valid = 1'b0; bus.rx_ready = 1'b0; bus.uart_wait = 1'b0;
        bus.uart_ready = 1'b0; bus.uart_do = 8'h00;
        model_en = 1'b1;
        step();

        // T2: TX burst, 3-cycle spacing
        we_times.delete();
        tx_push(8'h41, 4, ok);
        tx_push(8'h42, 4, ok);
        tx_push(8'h43, 4, ok);
        wait_drain("t2_drain_timeout", 100);
        repeat (4) step();
        chk("t2_we_count", we_times.size(), 32'd3);
        if (we_times.size() == 3) begin
            chk("t2_spacing_1", we_times[1] - we_times[0], 32'd3);
            chk("t2_spacing_2", we_times[2] - we_times[1], 32'd3);
        end
        chk("t2_tx_level", {27'd0, bus.tx_level}, 32'd0);

        // T3: TX backpressure, FIFO fills at 16
        bus.uart_wait = 1'b1;
        step();
        base_we = we_cnt;
        acc = 0;
        for (int i = 0; i < 20; i++) begin
            tx_push(8'(8'h60 + i), 2, ok);
            if (ok) acc++;
        end
        @(negedge clk);
        chk("t3_accepted", acc, 32'd16);
        chk("t3_tx_ready_full", {31'd0, bus.tx_ready}, 32'd0);
        chk("t3_tx_level_full", {27'd0, bus.tx_level}, 32'd16);
        chk("t3_no_we_while_wait", we_cnt - base_we, 32'd0);
        step();
        bus.uart_wait = 1'b0;
        wait_drain("t3_drain_timeout", 200);
        repeat (4) step();
        chk("t3_we_count", we_cnt - base_we, 32'd16);
        chk("t3_tx_level_end", {27'd0, bus.tx_level}, 32'd0);

        // T4: RX two bytes
        bus.rx_ready = 1'b1;
        base_re = re_cnt;
        offer_rx(8'h55);
        offer_rx(8'hAA);
        wait_drain("t4_drain_timeout", 100);
        repeat (4) step();
        chk("t4_re_count", re_cnt - base_re, 32'd2);
        chk("t4_rx_valid_end", {31'd0, bus.rx_valid}, 32'd0);

        // T5: RX FIFO full stalls uart_re
        bus.rx_ready = 1'b0;
        base_re = re_cnt;
        for (int i = 0; i < 20; i++) offer_rx(8'(8'h10 + i));
        repeat (150) step();
        @(negedge clk);
        chk("t5_re_at_full", re_cnt - base_re, 32'd16);
        chk("t5_rx_level_full", {27'd0, bus.rx_level}, 32'd16);
        chk("t5_rx_head", {24'd0, bus.rx_data}, 32'h10);
        step();
        bus.rx_ready = 1'b1;
        wait_drain("t5_drain_timeout", 300);
        repeat (4) step();
        chk("t5_re_total", re_cnt - base_re, 32'd20);
        chk("t5_rx_level_end", {27'd0, bus.rx_level}, 32'd0);

        // T6: reset mid-operation with both FIFOs partly full
        bus.rx_ready = 1'b0;
        bus.uart_wait = 1'b1;
        step();
        for (int i = 0; i < 8; i++) tx_push(8'(8'hC0 + i), 2, ok);
        for (int i = 0; i < 10; i++) offer_rx(8'(8'hD0 + i));
        n = 0;
        while (bus.rx_level < 8 && n < 100) begin @(negedge clk); n++; end
        chk("t6_rx_fill_timeout", (n >= 100) ? 32'd1 : 32'd0, 32'd0);
        step();
        bus.uart_wait = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.uart_we && n < 20);
        chk("t6_we_timeout", (n >= 20) ? 32'd1 : 32'd0, 32'd0);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_we_drop", {31'd0, bus.uart_we}, 32'd0);
        chk("t6_re_drop", {31'd0, bus.uart_re}, 32'd0);
        chk("t6_tx_level", {27'd0, bus.tx_level}, 32'd0);
        chk("t6_rx_level", {27'd0, bus.rx_level}, 32'd0);
        chk("t6_tx_ready", {31'd0, bus.tx_ready}, 32'd1);
        chk("t6_rx_valid", {31'd0, bus.rx_valid}, 32'd0);
        tx_exp.delete();
        rx_exp.delete();
        core_q.delete();
        repeat (2) step();
        reset = 1'b0;
        bus.rx_ready = 1'b1;
        base_we = we_cnt;
        repeat (20) step();
        @(negedge clk);
        chk("t6_no_stale_we", we_cnt - base_we, 32'd0);
        chk("t6_rx_data_clear", {24'd0, bus.rx_data}, 32'd0);
        chk("t6_uart_di_clear", {24'd0, bus.uart_di}, 32'd0);
        step();
        base_re = re_cnt;
        tx_push(8'h5A, 4, ok);
        offer_rx(8'h3C);
        wait_drain("t6_post_drain_timeout", 100);
        repeat (4) step();
        chk("t6_post_we", we_cnt - base_we, 32'd1);
        chk("t6_post_re", re_cnt - base_re, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
